cs_product_resolver: RTL
========================

Name: cs_product_resolver

Overview:
- Consumer of the carry-save row pair (pp0, pp1) produced by the signed 8x8 partial-product reduction tree.
- Resolves the pair into a single two's-complement product with a sequential carry-propagate adder that processes CHUNK bits per cycle, carrying between cycles in a register.
- Sits between the multiplier reduction stage and the posit FMA alignment/normalisation stage.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16: width of pp0, pp1 and the product.
- CHUNK, 4: bits added per cycle. Must divide WIDTH; elaboration error otherwise. CHUNK = WIDTH gives a single-cycle add.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pp0/pp1 valid.
- in_ready  out  1  resolver can accept a pair this cycle.
- pp0  in  WIDTH  carry-save sum row.
- pp1  in  WIDTH  carry-save carry row.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  WIDTH  (pp0 + pp1) mod 2^WIDTH.
- busy  out  1  high in ADD state.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; out_valid = 0; product = 0; busy = 0.
  - Carry register = 0; chunk counter = 0; operand registers = 0.
  - in_ready = 1 once reset deasserts.
- State machine, three states:
  - IDLE: in_ready = 1. On in_valid & in_ready, register pp0/pp1, clear carry and counter, go to ADD.
  - ADD: in_ready = 0, busy = 1. Each cycle, add chunk k = counter of both operand registers plus the carry register. Write the result into product bits [k*CHUNK +: CHUNK]. Store the chunk carry-out in the carry register. Increment the counter. On counter == WIDTH/CHUNK - 1, go to DONE and set out_valid = 1 at that edge.
  - DONE: out_valid = 1; product held stable while out_ready = 0.
    - out_ready = 1 and in_valid = 0: go to IDLE, out_valid = 0.
    - out_ready = 1 and in_valid = 1: accept the new pair in the same cycle and go directly to ADD.
- in_ready = (state == IDLE) | (state == DONE & out_ready). This is combinational from out_ready; no combinational path from in_valid to any output.
- Latency: out_valid rises WIDTH/CHUNK clock edges after the accepting edge (default 4). Back-to-back throughput is one result per WIDTH/CHUNK + 1 cycles with out_ready held high.
- Arithmetic:
  - Unsigned modular add; carry out of the MSB chunk is discarded.
  - No sign extension is needed: the signed product range fits in WIDTH. Overflow past bit WIDTH-1 is by design the carry-save wraparound and must be dropped.
- Product bits not yet written during ADD hold their previous value. product is only defined while out_valid = 1.
- in_valid while in_ready = 0 is ignored. The upstream must hold pp0/pp1 until it sees the handshake.
- Reset asserted mid-ADD or in DONE: immediate return to the reset values; the partial result is lost and no out_valid pulse is produced.
- out_valid must not drop without out_ready handshake (AXI-style stability). product must not change while out_valid = 1 and out_ready = 0.

Decomposition:
- Shared package (mult_pkg):
  - WIDTH default constant.
  - resolver_state_t enum (IDLE, ADD, DONE).
  - Function computing NCHUNK = WIDTH/CHUNK and counter width clog2(NCHUNK), minimum 1 bit.
- One sub-module, cs_chunk_adder: combinational CHUNK-bit adder with carry-in/carry-out, instantiated once and muxed by the chunk counter.

Test Plan:
- pp0 = 0x0003, pp1 = 0x0005, out_ready = 1 → out_valid exactly 4 edges after accept; product = 0x0008.
- pp0 = 0x3FFF, pp1 = 0x0001 (carry ripples through all chunks) → product = 0x4000, i.e. (-128)*(-128).
- pp0 = 0xFFFF, pp1 = 0x0001 → product = 0x0000; MSB carry discarded; no other flag is raised.
- Hold out_ready = 0 for 10 cycles after pp0 = 0x1234, pp1 = 0x0F0F:
  - out_valid stays 1; product stays 0x2143; in_ready stays 0.
  - Raise out_ready together with in_valid (pp0 = 0x0001, pp1 = 0x0001) → same-cycle accept; next product = 0x0002 after 4 edges.
- Assert rst_n = 0 two cycles into ADD → out_valid = 0, product = 0, busy = 0 immediately. After release, a new pair (0x00FF + 0xFF01) → product = 0x0000 with no stale carry.
- CHUNK = 16 build: pp0 = 0x8000, pp1 = 0x7FFF → product = 0xFFFF, out_valid 1 edge after accept.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the signed multiplier datapath.
// Used by the carry-save product resolver and its chunk adder.
package mult_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } resolver_state_t;

    function automatic int unsigned chunk_count(input int unsigned width, input int unsigned chunk);
        if (chunk == 0) begin
            return 1;
        end
        return width / chunk;
    endfunction

    // A single-chunk build still needs a one-bit counter to keep the datapath legal.
    function automatic int unsigned counter_width(input int unsigned nchunk);
        if (nchunk <= 1) begin
            return 1;
        end
        return $clog2(nchunk);
    endfunction

endpackage

// File: rtl/cs_chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in and carry-out.
// One slice of the sequential carry-propagate add in the product resolver.
module cs_chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum   = total[CHUNK-1:0];
        cout  = total[CHUNK];
    end

endmodule

// File: rtl/cs_product_resolver.sv
// Resolves a carry-save row pair into a two's-complement product using a
// sequential carry-propagate adder that handles CHUNK bits per cycle.
module cs_product_resolver
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pp0,
    input  logic [WIDTH-1:0] pp1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    localparam int unsigned NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int unsigned CW     = counter_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("cs_product_resolver: CHUNK must be non-zero and divide WIDTH");
        end
    endgenerate

    resolver_state_t  state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             chunk_cout;

    // Ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    end

    always_comb begin
        a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    end

    cs_chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .sum (sum_chunk),
        .cout(chunk_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        product_d   = product_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = ADD;
                    a_d         = pp0;
                    b_d         = pp1;
                    carry_d     = 1'b0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            ADD: begin
                product_d[cnt_q*CHUNK +: CHUNK] = sum_chunk;
                carry_d = chunk_cout;
                if (cnt_q == LAST) begin
                    // Carry out of the top chunk is the carry-save wraparound; it is dropped here.
                    state_d     = DONE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d     = ADD;
                        a_d         = pp0;
                        b_d         = pp1;
                        carry_d     = 1'b0;
                        cnt_d       = '0;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            product_q   <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            product_q   <= product_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        product   = product_q;
        busy      = busy_q;
    end

endmodule
